// File: rtl/result_drain_packer.sv
`timescale 1ns/1ps
// Drains per-tile result FIFOs round-robin and packs LANES results into one output word.
// A tile stays locked until its word is accepted; partial words are emitted only under flush.
module result_drain_packer #(
  parameter int NUM_TILES  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int OUT_WIDTH  = LANES*DATA_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [NUM_TILES-1:0]            i_fifo_empty,
  input  logic [NUM_TILES*DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic [NUM_TILES-1:0]            o_fifo_rd_en,
  input  logic                            i_flush,
  output logic                            o_wr_valid,
  input  logic                            i_wr_ready,
  output logic [OUT_WIDTH-1:0]            o_wr_data,
  output logic [$clog2(NUM_TILES)-1:0]    o_wr_tile,
  output logic [$clog2(LANES):0]          o_wr_count,
  output logic                            o_busy,
  output logic [31:0]                     o_word_cnt
);
  localparam int TW = $clog2(NUM_TILES);
  localparam int CW = $clog2(LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TW-1:0]         r_rr_ptr;
  logic [TW-1:0]         r_tile;
  logic [TW-1:0]         w_pick;
  logic [TW-1:0]         w_idx;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_captured;
  logic                  r_inflight;
  logic [OUT_WIDTH-1:0]  r_data;
  logic [31:0]           r_word_cnt;
  logic                  w_rd;
  logic                  w_full;
  logic                  w_flush;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Walk offsets from the far end so the nearest non-empty tile after rr_ptr wins.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = r_rr_ptr;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      w_idx = TW'((int'(r_rr_ptr) + i) % NUM_TILES);
      if (!i_fifo_empty[w_idx]) w_pick = w_idx;
    end
  end

  assign w_rd      = (r_state == S_FILL) && !i_fifo_empty[r_tile] && (r_issued < CW'(LANES));
  assign w_rd_data = i_fifo_rd_data[r_tile*DATA_WIDTH +: DATA_WIDTH];
  assign w_full    = r_inflight && (r_captured == CW'(LANES - 1));
  assign w_flush   = i_flush && !r_inflight && i_fifo_empty[r_tile] && (r_captured != '0);
  assign w_accept  = (r_state == S_EMIT) && i_wr_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!(&i_fifo_empty)) w_next = S_FILL;
      S_FILL:  if (w_full || w_flush) w_next = S_EMIT;
      S_EMIT:  if (i_wr_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_rd_en = '0;
    if (w_rd) o_fifo_rd_en[r_tile] = 1'b1;
    o_wr_valid = (r_state == S_EMIT);
    o_busy     = (r_state != S_IDLE);
    o_wr_data  = (r_state == S_EMIT) ? r_data : '0;
    o_wr_tile  = (r_state == S_EMIT) ? r_tile : '0;
    o_wr_count = (r_state == S_EMIT) ? r_captured : '0;
    o_word_cnt = r_word_cnt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_ptr   <= '0;
      r_tile     <= '0;
      r_issued   <= '0;
      r_captured <= '0;
      r_inflight <= 1'b0;
      r_data     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= w_rd;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_FILL) begin
            r_tile     <= w_pick;
            r_issued   <= '0;
            r_captured <= '0;
            r_data     <= '0;
          end
        end
        S_FILL: begin
          if (w_rd) r_issued <= r_issued + 1'b1;
          // Read data arrives one cycle after its strobe, so capture trails issue by one.
          if (r_inflight) begin
            r_data[int'(r_captured)*DATA_WIDTH +: DATA_WIDTH] <= w_rd_data;
            r_captured <= r_captured + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            r_rr_ptr   <= (r_tile == TW'(NUM_TILES - 1)) ? '0 : r_tile + 1'b1;
            r_data     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain_packer.sv
`timescale 1ns/1ps
// Bench for result_drain_packer: per-tile FIFO models plus a transaction-level model
// that picks tiles round-robin and packs up to LANES queued results per word.
module tb_result_drain_packer;
  localparam int NT = 4;
  localparam int DW = 16;
  localparam int LN = 16;
  localparam int OW = LN*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NT-1:0] fe;
  logic [NT-1:0] rd_en;
  logic [NT*DW-1:0] rd_data;
  logic          flush = 1'b0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [OW-1:0] wr_data;
  logic [1:0]    wr_tile;
  logic [4:0]    wr_count;
  logic          busy;
  logic [31:0]   word_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  result_drain_packer #(.NUM_TILES(NT), .DATA_WIDTH(DW), .LANES(LN), .OUT_WIDTH(OW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fifo_empty(fe), .i_fifo_rd_data(rd_data),
    .o_fifo_rd_en(rd_en), .i_flush(flush), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_data(wr_data), .o_wr_tile(wr_tile), .o_wr_count(wr_count), .o_busy(busy),
    .o_word_cnt(word_cnt)
  );

  // Tile FIFO models: empty is combinational, read data registered one cycle after rd_en.
  logic [DW-1:0] mem [NT][256];
  logic [7:0]    wp  [NT] = '{default: 8'd0};
  logic [7:0]    rp  [NT] = '{default: 8'd0};
  logic [DW-1:0] rdd [NT] = '{default: '0};

  for (genvar g = 0; g < NT; g++) begin : g_fifo
    assign fe[g] = (wp[g] == rp[g]);
    assign rd_data[g*DW +: DW] = rdd[g];
  end

  always @(posedge clk)
    for (int t = 0; t < NT; t++)
      if (rd_en[t] && wp[t] != rp[t]) begin
        rdd[t] <= mem[t][rp[t]];
        rp[t]  <= rp[t] + 8'd1;
      end

  // Monitor: accepted words and read strobes, sampled mid-cycle.
  int            cyc = 0;
  logic [OW-1:0] g_data[$];
  int            g_tile[$];
  int            g_cnt[$];
  int            g_cyc[$];
  int            rd_cyc[$];
  int            rd_tile[$];
  int            multi_rd = 0;
  int            emit_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        g_data.push_back(wr_data);
        g_tile.push_back(int'(wr_tile));
        g_cnt.push_back(int'(wr_count));
        g_cyc.push_back(cyc);
      end
      if (rd_en != '0) begin
        if (!$onehot(rd_en)) multi_rd++;
        if (wr_valid) emit_rd++;
        for (int t = 0; t < NT; t++)
          if (rd_en[t]) begin
            rd_cyc.push_back(cyc);
            rd_tile.push_back(t);
          end
      end
    end
  end

  // Reference model: queued contents per tile and the round-robin pointer.
  logic [DW-1:0] mq [NT][$];
  int            m_rr = 0;
  int            m_words = 0;

  task automatic m_emit(output logic [OW-1:0] w, output int tl, output int cnt);
    int t;
    t = -1;
    for (int i = 0; i < NT; i++)
      if (t < 0 && mq[(m_rr + i) % NT].size() > 0) t = (m_rr + i) % NT;
    w = '0;
    cnt = 0;
    tl = t;
    if (t >= 0) begin
      while (cnt < LN && mq[t].size() > 0) begin
        w[cnt*DW +: DW] = mq[t].pop_front();
        cnt++;
      end
      m_rr = (t + 1) % NT;
      m_words++;
    end
  endtask

  task automatic load(input int t, input int n, input int base);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = (base < 0) ? DW'($urandom) : DW'(base + i);
      mem[t][wp[t]] = v;
      wp[t] = wp[t] + 8'd1;
      mq[t].push_back(v);
    end
  endtask

  task automatic do_reset(input bit clr);
    rst_n = 1'b0;
    flush = 1'b0;
    wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (clr)
      for (int t = 0; t < NT; t++) begin
        wp[t] = rp[t];
        mq[t].delete();
      end
    m_rr = 0;
    m_words = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (g_data.size() < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (g_data.size() < target) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d words, need %0d", nm, g_data.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({rd_en, wr_valid, wr_data, wr_tile, wr_count, busy, word_cnt} !== '0)
      $display("FAIL reset_outputs: rd_en=%h vld=%b tile=%0d cnt=%0d busy=%b words=%0d, want all 0",
               rd_en, wr_valid, wr_tile, wr_count, busy, word_cnt);
    else n_pass++;
    do_reset(1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || rd_en !== '0) $display("FAIL idle_empty: busy=%b rd_en=%h, want 0/0", busy, rd_en);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [OW-1:0] ew, w;
    int et, ec, r0, g0, n0;
    do_reset(1);
    wr_ready = 1'b1;
    r0 = rd_cyc.size();
    g0 = g_data.size();
    load(0, 16, 16'h3C00);
    m_emit(ew, et, ec);
    wait_words(g0 + 1, 100, "single");
    if (g_data.size() > g0) begin
      n0 = 0;
      for (int i = r0; i < rd_tile.size(); i++) if (rd_tile[i] == 0) n0++;
      n_chk++;
      if (n0 != 16 || rd_tile.size() - r0 != 16) $display("FAIL single_rd_pulses: tile0=%0d total=%0d, want 16/16", n0, rd_tile.size() - r0);
      else n_pass++;
      n_chk++;
      if (rd_cyc.size() - r0 < 16 || rd_cyc[r0 + 15] - rd_cyc[r0] != 15)
        $display("FAIL single_back_to_back: pulses not on 16 consecutive cycles");
      else n_pass++;
      n_chk++;
      if (g_cyc[g0] - rd_cyc[r0] != LN + 1) $display("FAIL single_latency: got %0d want %0d", g_cyc[g0] - rd_cyc[r0], LN + 1);
      else n_pass++;
      w = g_data[g0];
      n_chk++;
      if (w[15:0] !== 16'h3C00 || w[OW-1 -: DW] !== 16'h3C0F || w !== ew)
        $display("FAIL single_data: got %h want %h", w, ew);
      else n_pass++;
      n_chk++;
      if (g_tile[g0] != et || g_cnt[g0] != ec || ec != 16)
        $display("FAIL single_tile_count: got %0d/%0d want %0d/16", g_tile[g0], g_cnt[g0], et);
      else n_pass++;
      n_chk++;
      if (word_cnt !== 32'(m_words)) $display("FAIL single_word_cnt: got %0d want %0d", word_cnt, m_words);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [OW-1:0] ew [8];
    int et [8];
    int ec [8];
    int g0;
    do_reset(1);
    wr_ready = 1'b1;
    g0 = g_data.size();
    for (int t = 0; t < NT; t++) load(t, 32, -1);
    for (int i = 0; i < 8; i++) m_emit(ew[i], et[i], ec[i]);
    wait_words(g0 + 8, 600, "rr");
    for (int i = 0; i < 8; i++)
      if (g_data.size() > g0 + i) begin
        n_chk++;
        if (g_tile[g0+i] != et[i] || g_cnt[g0+i] != ec[i] || g_data[g0+i] !== ew[i])
          $display("FAIL rr_word%0d: tile=%0d cnt=%0d data=%h, want tile=%0d cnt=%0d data=%h",
                   i, g_tile[g0+i], g_cnt[g0+i], g_data[g0+i], et[i], ec[i], ew[i]);
        else n_pass++;
      end
    n_chk++;
    if (word_cnt !== 32'(m_words)) $display("FAIL rr_word_cnt: got %0d want %0d", word_cnt, m_words);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [OW-1:0] ew, w;
    int et, ec, g0;
    do_reset(1);
    wr_ready = 1'b1;
    flush = 1'b1;
    g0 = g_data.size();
    load(2, 5, -1);
    m_emit(ew, et, ec);
    wait_words(g0 + 1, 100, "flush");
    if (g_data.size() > g0) begin
      w = g_data[g0];
      n_chk++;
      if (g_cnt[g0] != 5 || g_tile[g0] != 2 || ec != 5 || et != 2)
        $display("FAIL flush_tile_count: got %0d/%0d want 2/5", g_tile[g0], g_cnt[g0]);
      else n_pass++;
      n_chk++;
      if (w[OW-1:5*DW] !== '0 || w !== ew) $display("FAIL flush_data: got %h want %h", w, ew);
      else n_pass++;
    end
    flush = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] ew, hold;
    int et, ec, g0, e0, k, stable;
    do_reset(1);
    e0 = emit_rd;
    g0 = g_data.size();
    wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (word_cnt !== 32'd0 || g_data.size() != g0) $display("FAIL ready_idle: words=%0d, want 0", word_cnt);
    else n_pass++;
    wr_ready = 1'b0;
    load(3, 16, -1);
    m_emit(ew, et, ec);
    k = 0;
    while (!wr_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (!wr_valid) $display("FAIL bp_valid_timeout: valid=%b want 1", wr_valid);
    else n_pass++;
    hold = wr_data;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wr_valid && wr_data === hold && wr_tile === 2'd3 && wr_count === 5'd16 && rd_en === '0) stable++;
    end
    n_chk++;
    if (stable != 10) $display("FAIL bp_hold: stable cycles=%0d want 10", stable);
    else n_pass++;
    wr_ready = 1'b1;
    wait_words(g0 + 1, 10, "bp");
    if (g_data.size() > g0) begin
      n_chk++;
      if (g_data[g0] !== ew || g_tile[g0] != et) $display("FAIL bp_data: got %h want %h", g_data[g0], ew);
      else n_pass++;
    end
    n_chk++;
    if (word_cnt !== 32'(m_words)) $display("FAIL bp_word_cnt: got %0d want %0d", word_cnt, m_words);
    else n_pass++;
    n_chk++;
    if (emit_rd != e0 || multi_rd != 0) $display("FAIL rd_rules: emit reads=%0d multi-bit=%0d, want 0/0", emit_rd - e0, multi_rd);
    else n_pass++;
  endtask

  task automatic test_dry();
    logic [OW-1:0] ew;
    int et, ec, g0, r0;
    do_reset(1);
    wr_ready = 1'b1;
    g0 = g_data.size();
    r0 = rd_cyc.size();
    load(1, 7, -1);
    repeat (30) @(posedge clk);
    #1;
    n_chk++;
    if (g_data.size() != g0 || busy !== 1'b1 || rd_cyc.size() - r0 != 7)
      $display("FAIL dry_pause: words=%0d busy=%b reads=%0d, want 0/1/7", g_data.size() - g0, busy, rd_cyc.size() - r0);
    else n_pass++;
    load(1, 9, -1);
    m_emit(ew, et, ec);
    wait_words(g0 + 1, 100, "dry");
    if (g_data.size() > g0) begin
      n_chk++;
      if (g_data[g0] !== ew || g_cnt[g0] != 16 || g_tile[g0] != 1)
        $display("FAIL dry_word: got %h cnt=%0d tile=%0d want %h cnt=16 tile=1", g_data[g0], g_cnt[g0], g_tile[g0], ew);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] ew;
    int et, ec, g0, r0, k;
    do_reset(1);
    wr_ready = 1'b1;
    g0 = g_data.size();
    load(0, 16, -1);
    m_emit(ew, et, ec);
    wait_words(g0 + 1, 100, "rst_pre");
    r0 = rd_cyc.size();
    load(1, 16, -1);
    k = 0;
    while (rd_cyc.size() - r0 < 9 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rd_en, wr_valid, wr_data, wr_tile, wr_count, busy, word_cnt} !== '0)
      $display("FAIL reset_mid_outputs: rd_en=%h busy=%b words=%0d, want all 0", rd_en, busy, word_cnt);
    else n_pass++;
    for (int i = 0; i < rd_cyc.size() - r0; i++) void'(mq[1].pop_front());
    m_rr = 0;
    m_words = 0;
    load(0, 16, -1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    g0 = g_data.size();
    m_emit(ew, et, ec);
    wait_words(g0 + 1, 100, "rst_post");
    if (g_data.size() > g0) begin
      n_chk++;
      if (g_tile[g0] != 0 || et != 0 || g_data[g0] !== ew)
        $display("FAIL reset_priority: tile=%0d data=%h want tile=0 data=%h", g_tile[g0], g_data[g0], ew);
      else n_pass++;
      n_chk++;
      if (word_cnt !== 32'd1) $display("FAIL reset_word_cnt: got %0d want 1", word_cnt);
      else n_pass++;
    end
    do_reset(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_backpressure();
    test_dry();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/result_drain_packer.md
RESULT_DRAIN_PACKER -- requirements
Module: result_drain_packer

Interface
REQ-001 The block SHALL have these parameters: NUM_TILES, default 4, number of tile result FIFOs drained; DATA_WIDTH, default 16, FP16 result width; LANES, default 16, results packed per output word; OUT_WIDTH, default LANES*DATA_WIDTH, output word width.
REQ-002 The block SHALL have one clock, i_clk; reset i_reset_n is asynchronous and active-low.
REQ-003 The block SHALL have these ports, clock and reset first:
- i_clk  in  1  clock.
- i_reset_n  in  1  async active-low reset.
- i_fifo_empty  in  NUM_TILES  per-tile FIFO empty flag.
- i_fifo_rd_data  in  NUM_TILES*DATA_WIDTH  per-tile read data; tile t occupies bits [t*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after rd_en.
- o_fifo_rd_en  out  NUM_TILES  per-tile read strobe.
- i_flush  in  1  level; emit a partial word when the locked tile runs dry.
- o_wr_valid  out  1  output word valid.
- i_wr_ready  in  1  downstream accept.
- o_wr_data  out  OUT_WIDTH  packed results.
- o_wr_tile  out  $clog2(NUM_TILES)  source tile of o_wr_data.
- o_wr_count  out  $clog2(LANES)+1  number of valid lanes, 1..LANES.
- o_busy  out  1  high when the state is not IDLE.
- o_word_cnt  out  32  words accepted since reset; wraps modulo 2^32.

Function
REQ-004 The block SHALL implement the states IDLE, FILL and EMIT.
REQ-005 In IDLE, when any i_fifo_empty bit is 0, the block SHALL lock the first non-empty tile at or after rr_ptr (cyclic) and move to FILL the next cycle, with lane index and issue/capture counters cleared.
REQ-006 In FILL, o_fifo_rd_en SHALL be asserted only for the locked tile, only while that tile's i_fifo_empty=0, and only while issued<LANES; at most one bit SHALL ever be set.
REQ-007 Data SHALL be captured 1 cycle after each asserted rd_en, into lane captured, bits [captured*DATA_WIDTH +: DATA_WIDTH]; the first result goes to lane 0.
REQ-008 Reads SHALL be issued back-to-back, one per cycle, while the tile is non-empty.
REQ-009 When the locked tile goes empty mid-word without i_flush, the block SHALL stay in FILL with the tile locked, and resume when the tile is non-empty.
REQ-010 When captured reaches LANES, the block SHALL enter EMIT with o_wr_count=LANES.
REQ-011 Flush: in FILL, when i_flush=1, no read is in flight, the locked tile is empty and captured>0, the block SHALL enter EMIT with o_wr_count=captured and unfilled lanes zero.
REQ-012 In EMIT, o_wr_valid SHALL be 1, and o_wr_data, o_wr_tile and o_wr_count SHALL be held stable until i_wr_ready=1; no FIFO reads SHALL occur in EMIT.
REQ-013 On the cycle o_wr_valid&&i_wr_ready, the block SHALL: increment o_word_cnt; set rr_ptr to (locked tile+1) mod NUM_TILES; clear the data register; return to IDLE.
REQ-014 i_wr_ready while o_wr_valid=0 SHALL have no effect.
REQ-015 An i_flush asserted in IDLE or EMIT SHALL have no effect.
REQ-016 Minimum latency SHALL be: first rd_en 1 cycle after leaving IDLE; o_wr_valid LANES+1 cycles after the first rd_en when the tile is never empty.

Reset
REQ-017 While i_reset_n=0, the block SHALL hold: state IDLE; o_fifo_rd_en=0; o_wr_valid=0; o_wr_data=0; o_wr_tile=0; o_wr_count=0; o_busy=0; o_word_cnt=0; rr_ptr=0; counters 0.
REQ-018 Reset asserted mid-FILL or mid-EMIT SHALL discard partial data immediately; after release, tile 0 SHALL have first priority.

Verification
REQ-019 The bench SHALL cover: tile 0 holding 16 results 0x3C00..0x3C0F, ready=1 -> 16 consecutive rd_en[0] pulses, then one word with lane0=0x3C00, lane15=0x3C0F, tile=0, count=16, o_word_cnt=1.
REQ-020 The bench SHALL cover: all 4 tiles holding 32 results each -> emitted tile order 0,1,2,3,0,1,2,3, then 8 words.
REQ-021 The bench SHALL cover: tile 2 holding 5 results and i_flush=1 -> one word with count=5, lanes 5..15 zero, tile=2.
REQ-022 The bench SHALL cover: i_wr_ready low for 10 cycles in EMIT -> o_wr_valid and the data held stable, no rd_en; accepted on the ready cycle.
REQ-023 The bench SHALL cover: tile 1 running dry after 7 results without flush, then 9 more results written -> rd_en pauses, and one full word (count=16) is emitted in order.
REQ-024 The bench SHALL cover: reset asserted after 8 captured results -> all outputs 0 immediately; after release, the first word comes from the lowest non-empty tile.
